minv_seq_ctrl: RTL and testbench

Sequencer for the 256-bit modular-inverse unit (`MINV_modify`). Accepts one full-width request (operand `a`, modulus `p`) from a host and serialises both operands into the unit over its 16-bit `datain` port. It then pulses `minv_en`, waits for `minv_rdy`, and drains `regx1out`/`regx2out` back into 256-bit result registers. It replaces the hand-driven load/start/read sequence with a single req/done handshake for the surrounding crypto datapath.

---
 rtl/minv_pkg.sv | 20 ++
 rtl/minv_word_ser.sv | 44 ++++
 rtl/minv_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_minv_seq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minv_pkg.sv
// Shared state encoding and default sizing for the modular-inverse sequencer.
// The optional WAIT watchdog is enabled by defining MINV_TIMEOUT_EN.
package minv_pkg;

  localparam int WORD_W          = 16;
  localparam int OP_W            = 256;
  localparam int NWORDS          = OP_W / WORD_W;
  localparam int TIMEOUT_CYC_DEF = 65535;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADP,
    S_START,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

endpackage

// File: rtl/minv_word_ser.sv
// Full-width to word serialiser: load presents word 0, each shift presents the next
// word, LS word first; last flags that the final word is on the output.
module minv_word_ser #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     shift,
  input  logic                     clear,
  input  logic [WORD_W*NWORDS-1:0] din,
  output logic [WORD_W-1:0]        word,
  output logic                     last
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [WORD_W*NWORDS-1:0] sreg;
  logic [CW-1:0]            cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      sreg <= '0;
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= din[WORD_W-1:0];
      sreg <= din >> WORD_W;
      cnt  <= '0;
    end else if (shift) begin
      word <= sreg[WORD_W-1:0];
      sreg <= sreg >> WORD_W;
      cnt  <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(NWORDS - 1));

endmodule

// File: rtl/minv_seq_ctrl.sv
// Request/done sequencer for the 256-bit modular-inverse unit: serialises a and p,
// starts the unit, waits for ready and collects both result vectors.
// Define MINV_TIMEOUT_EN to add the WAIT watchdog and the timeout port.
module minv_seq_ctrl
  import minv_pkg::*;
#(
  parameter int WORD_W      = minv_pkg::WORD_W,
  parameter int OP_W        = minv_pkg::OP_W,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = minv_pkg::TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [OP_W-1:0]   a_in,
  input  logic [OP_W-1:0]   p_in,
  output logic              busy,
  output logic              done,
  output logic [OP_W-1:0]   res_x1,
  output logic [OP_W-1:0]   res_x2,
  output logic              res_flag,
`ifdef MINV_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic [WORD_W-1:0] datain,
  output logic              loada,
  output logic              loadp,
  output logic              minv_en,
  output logic              outx1,
  output logic              outx2,
  input  logic [WORD_W-1:0] regx1out,
  input  logic [WORD_W-1:0] regx2out,
  input  logic              minv_rdy,
  input  logic              minv_flag
);

  localparam int unsigned NW  = OP_W / WORD_W;
  localparam int          RCW = $clog2(NW + RD_LAT + 1);

  state_t          state;
  logic [OP_W-1:0] p_reg;
  logic [RCW-1:0]  rcnt;
  logic [RCW-1:0]  widx;
`ifdef MINV_TIMEOUT_EN
  logic [15:0]     wcnt;
`endif

  logic              ser_load;
  logic              ser_shift;
  logic              ser_clear;
  logic              ser_last;
  logic [OP_W-1:0]   ser_din;
  logic [WORD_W-1:0] ser_word;

  // One serialiser serves both phases: a is loaded on accept, p is reloaded
  // on the edge that retires the last a word so datain never gaps.
  always_comb begin
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_clear = 1'b0;
    ser_din   = p_reg;
    case (state)
      S_IDLE: begin
        ser_load = req;
        ser_din  = a_in;
      end
      S_LOADA: begin
        if (ser_last) ser_load = 1'b1;
        else          ser_shift = 1'b1;
      end
      S_LOADP: begin
        if (ser_last) ser_clear = 1'b1;
        else          ser_shift = 1'b1;
      end
      default: ;
    endcase
  end

  minv_word_ser #(
    .WORD_W (WORD_W),
    .NWORDS (NW)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .shift (ser_shift),
    .clear (ser_clear),
    .din   (ser_din),
    .word  (ser_word),
    .last  (ser_last)
  );

  assign datain = ser_word;
  assign widx   = rcnt - RCW'(RD_LAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      loada    <= 1'b0;
      loadp    <= 1'b0;
      minv_en  <= 1'b0;
      outx1    <= 1'b0;
      outx2    <= 1'b0;
      res_flag <= 1'b0;
      res_x1   <= '0;
      res_x2   <= '0;
      p_reg    <= '0;
      rcnt     <= '0;
`ifdef MINV_TIMEOUT_EN
      timeout  <= 1'b0;
      wcnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_LOADA;
            p_reg    <= p_in;
            loada    <= 1'b1;
            busy     <= 1'b1;
            res_x1   <= '0;
            res_x2   <= '0;
            res_flag <= 1'b0;
`ifdef MINV_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end
        S_LOADA: begin
          if (ser_last) begin
            state <= S_LOADP;
            loada <= 1'b0;
            loadp <= 1'b1;
          end
        end
        S_LOADP: begin
          if (ser_last) begin
            state   <= S_START;
            loadp   <= 1'b0;
            minv_en <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_WAIT;
          minv_en <= 1'b0;
`ifdef MINV_TIMEOUT_EN
          wcnt    <= '0;
`endif
        end
        S_WAIT: begin
          if (minv_rdy) begin
            state    <= S_READ;
            res_flag <= minv_flag;
            outx1    <= 1'b1;
            outx2    <= 1'b1;
            rcnt     <= '0;
          end
`ifdef MINV_TIMEOUT_EN
          else if (wcnt == 16'(TIMEOUT_CYC)) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
`endif
        end
        S_READ: begin
          rcnt <= rcnt + RCW'(1);
          if (rcnt == RCW'(NW - 1)) begin
            outx1 <= 1'b0;
            outx2 <= 1'b0;
          end
          // Captures trail the outx strobes by RD_LAT, so READ overruns them.
          if (rcnt >= RCW'(RD_LAT)) begin
            for (int unsigned i = 0; i < NW; i++) begin
              if (widx == RCW'(i)) begin
                res_x1[i*WORD_W +: WORD_W] <= regx1out;
                res_x2[i*WORD_W +: WORD_W] <= regx2out;
              end
            end
          end
          if (rcnt == RCW'(NW - 1 + RD_LAT)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minv_seq_ctrl.sv
// Bench for minv_seq_ctrl with a behavioural modular-inverse unit and a result scoreboard.
module tb_minv_seq_ctrl;

  localparam int W   = 16;
  localparam int OPW = 256;
  localparam int NW  = 16;
  localparam logic [255:0] P25519 = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] BIG_A  = 256'h787968b4_fa32c3fd_2417842e_73bbfeff_2f3c848b_6831d7e0_ec65228b_3937e498;
  localparam logic [255:0] BIG_P  = 256'h8542d69e_4c044f18_e8b92435_bf6ff7de_45728391_5c45517d_722edb8b_08f1dfc3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic [OPW-1:0] a_in = '0;
  logic [OPW-1:0] p_in = '0;
  logic           busy, done, res_flag;
  logic [OPW-1:0] res_x1, res_x2;
  logic [W-1:0]   datain;
  logic           loada, loadp, minv_en, outx1, outx2;
  logic [W-1:0]   regx1out = '0;
  logic [W-1:0]   regx2out = '0;
  logic           minv_rdy = 1'b0;
  logic           minv_flag = 1'b0;
`ifdef MINV_TIMEOUT_EN
  logic           timeout;
`endif

  minv_seq_ctrl #(
    .WORD_W      (W),
    .OP_W        (OPW),
    .RD_LAT      (1),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .p_in      (p_in),
    .busy      (busy),
    .done      (done),
    .res_x1    (res_x1),
    .res_x2    (res_x2),
    .res_flag  (res_flag),
`ifdef MINV_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .datain    (datain),
    .loada     (loada),
    .loadp     (loadp),
    .minv_en   (minv_en),
    .outx1     (outx1),
    .outx2     (outx2),
    .regx1out  (regx1out),
    .regx2out  (regx2out),
    .minv_rdy  (minv_rdy),
    .minv_flag (minv_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [255:0] x1;
    logic [255:0] x2;
    logic         flag;
  } exp_t;

  typedef struct {
    logic [255:0] a;
    logic [255:0] p;
    logic [255:0] x1;
    logic         flag;
    int           delay;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference extended Euclid; returns 0 and ok=0 when gcd(a,p) != 1.
  function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] p, output logic ok);
    logic signed [263:0] t, nt, r, nr, q, tmp;
    t  = '0;
    nt = 264'sd1;
    r  = {8'd0, p};
    nr = {8'd0, a};
    for (int i = 0; i < 2000; i++) begin
      if (nr == 0) break;
      q   = r / nr;
      tmp = t - q * nt;
      t   = nt;
      nt  = tmp;
      tmp = r - q * nr;
      r   = nr;
      nr  = tmp;
    end
    ok = (r == 264'sd1);
    if (!ok) return '0;
    if (t < 0) t = t + $signed({8'd0, p});
    return t[255:0];
  endfunction

  // Behavioural unit: captures loaded words, answers rdy_delay cycles after
  // minv_en and streams results one cycle after each outx strobe.
  logic [255:0] a_got = '0, p_got = '0, m_x1 = '0, m_x2 = '0;
  logic         m_flag = 1'b0, prev_outx = 1'b0, wait_on = 1'b0;
  int la = 0, lp = 0, la_fin = 0, lp_fin = 0, en_cyc = 0, rdy_at = 0, ridx = 0;
  int outx_cnt = 0, done_cnt = 0, glitch_ack = 0;
  int glitch_req = 0, rdy_delay = 100;
  bit never_rdy = 1'b0;

  always @(negedge clk) begin
    minv_rdy = 1'b0;
    if (rst) begin
      la = 0; lp = 0; ridx = 0; prev_outx = 1'b0; wait_on = 1'b0;
      regx1out = '0; regx2out = '0;
    end else begin
      if (loada) begin
        if (la < NW) a_got[la*W +: W] = datain;
        la++;
      end
      if (loadp) begin
        if (lp < NW) p_got[lp*W +: W] = datain;
        lp++;
      end
      if (loada && glitch_req != glitch_ack) begin
        minv_rdy   = 1'b1;
        glitch_ack = glitch_req;
      end
      if (minv_en) begin
        en_cyc = cyc; la_fin = la; lp_fin = lp; la = 0; lp = 0; ridx = 0;
        m_x1    = modinv(a_got, p_got, m_flag);
        m_x2    = p_got - m_x1;
        wait_on = !never_rdy;
        rdy_at  = cyc + rdy_delay;
      end else if (wait_on && cyc == rdy_at) begin
        minv_rdy  = 1'b1;
        minv_flag = m_flag;
        wait_on   = 1'b0;
      end
      regx1out = '0;
      regx2out = '0;
      if (prev_outx && ridx < NW) begin
        regx1out = m_x1[ridx*W +: W];
        regx2out = m_x2[ridx*W +: W];
        ridx++;
      end
      prev_outx = outx1;
      if (outx1) outx_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s act=%0h exp=%0h", tag, name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [255:0] x1, input logic flag, input logic [255:0] p);
    exp_t x;
    x.x1 = x1; x.x2 = p - x1; x.flag = flag;
    return x;
  endfunction

  task automatic start_txn(input string tag, input logic [255:0] a, input logic [255:0] p,
                           input exp_t x, input int delay, input bit hold, output int e);
    rdy_delay = delay;
    sb.push_back(x);
    @(negedge clk);
    a_in = a; p_in = p; req = 1'b1;
    @(negedge clk);
    if (!hold) req = 1'b0;
    e = cyc;
    chk(tag, "busy_start", 256'(busy), 256'(1));
  endtask

  task automatic wait_done(input string tag, input int e, input int off);
    int   n = 0;
    exp_t x;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s.done_wait act=no_done exp=done", tag);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk(tag, "done_edge", 256'(cyc - e), 256'(off));
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard act=empty exp=entry", tag);
    end else begin
      x = sb.pop_front();
      chk(tag, "res_x1", res_x1, x.x1);
      chk(tag, "res_x2", res_x2, x.x2);
      chk(tag, "res_flag", 256'(res_flag), 256'(x.flag));
    end
    @(negedge clk);
    chk(tag, "done_width", 256'(done), 256'(0));
    chk(tag, "busy_after", 256'(busy), 256'(0));
  endtask

  task automatic finish_txn(input string tag, input int e, input int off, input logic [255:0] a, input logic [255:0] p);
    wait_done(tag, e, off);
    chk(tag, "a_words", a_got, a);
    chk(tag, "p_words", p_got, p);
    chk(tag, "a_cnt", 256'(la_fin), 256'(NW));
    chk(tag, "p_cnt", 256'(lp_fin), 256'(NW));
    chk(tag, "en_edge", 256'(en_cyc - e), 256'(32));
  endtask

  vec_t tbl[6];

  initial begin
    int   e, e2, d0, n;
    logic ok;
    exp_t x;

    tbl[0] = '{256'd5, 256'd11, 256'd9, 1'b1, 100};
    tbl[1] = '{256'd3, 256'd7, 256'd5, 1'b1, 1};
    tbl[2] = '{256'd4, 256'd8, 256'd0, 1'b0, 20};
    tbl[3] = '{P25519 - 256'd1, P25519, P25519 - 256'd1, 1'b1, 37};
    tbl[4] = '{256'd1, P25519, 256'd1, 1'b1, 5};
    tbl[5] = '{BIG_A, BIG_P, 256'd0, 1'b0, 60};
    tbl[5].x1   = modinv(BIG_A, BIG_P, ok);
    tbl[5].flag = ok;

    repeat (3) @(negedge clk);
    chk("reset", "outs", {busy, done, res_flag, loada, loadp, minv_en, outx1, outx2, datain}, '0);
    chk("reset", "res", res_x1 | res_x2, '0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].p,
                mk_exp(tbl[i].x1, tbl[i].flag, tbl[i].p), tbl[i].delay, 1'b0, e);
      finish_txn($sformatf("vec%0d", i), e, 50 + tbl[i].delay, tbl[i].a, tbl[i].p);
    end

    // Extra req pulses during LOADP and WAIT must be ignored.
    d0 = done_cnt;
    start_txn("ign", BIG_A, BIG_P, mk_exp(tbl[5].x1, tbl[5].flag, BIG_P), 100, 1'b0, e);
    while (cyc < e + 20) @(negedge clk);
    chk("ign", "in_loadp", 256'(loadp), 256'(1));
    a_in = ~BIG_A; p_in = ~BIG_P; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    while (cyc < e + 60) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    finish_txn("ign", e, 150, BIG_A, BIG_P);
    repeat (40) @(negedge clk);
    chk("ign", "single_done", 256'(done_cnt - d0), 256'(1));
    chk("ign", "idle_busy", 256'(busy), 256'(0));

    // Reset in the middle of READ.
    start_txn("rst", BIG_A, BIG_P, mk_exp(tbl[5].x1, tbl[5].flag, BIG_P), 30, 1'b0, e);
    n = 0;
    while (!outx1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst", "reached_read", 256'(outx1), 256'(1));
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst", "outs", {busy, done, res_flag, loada, loadp, minv_en, outx1, outx2, datain}, '0);
    chk("rst", "res", res_x1 | res_x2, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    start_txn("post_rst", 256'd5, 256'd11, mk_exp(256'd9, 1'b1, 256'd11), 100, 1'b0, e);
    finish_txn("post_rst", e, 150, 256'd5, 256'd11);

    // Spurious minv_rdy during LOADA.
    glitch_req++;
    start_txn("glitch", 256'd3, 256'd7, mk_exp(256'd5, 1'b1, 256'd7), 100, 1'b0, e);
    finish_txn("glitch", e, 150, 256'd3, 256'd7);
    chk("glitch", "pulsed", 256'(glitch_ack), 256'(glitch_req));

    // req held high through done: second request accepted on the first IDLE cycle.
    x = mk_exp(256'd9, 1'b1, 256'd11);
    start_txn("b2b0", 256'd5, 256'd11, x, 10, 1'b1, e);
    sb.push_back(x);
    wait_done("b2b0", e, 60);
    @(negedge clk);
    chk("b2b1", "busy_reaccept", 256'(busy), 256'(1));
    req = 1'b0;
    e2 = cyc;
    finish_txn("b2b1", e2, 60, 256'd5, 256'd11);

`ifdef MINV_TIMEOUT_EN
    never_rdy = 1'b1;
    d0 = outx_cnt;
    x.x1 = '0; x.x2 = '0; x.flag = 1'b0;
    start_txn("tmo", 256'd5, 256'd11, x, 100, 1'b0, e);
    finish_txn("tmo", e, 84, 256'd5, 256'd11);
    chk("tmo", "timeout", 256'(timeout), 256'(1));
    chk("tmo", "no_outx", 256'(outx_cnt - d0), 256'(0));
    never_rdy = 1'b0;
    start_txn("tmo_clr", 256'd3, 256'd7, mk_exp(256'd5, 1'b1, 256'd7), 10, 1'b0, e);
    chk("tmo_clr", "timeout", 256'(timeout), 256'(0));
    finish_txn("tmo_clr", e, 60, 256'd3, 256'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
